// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_BLOCK = 8;

    // Opcode values carried on the sub input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of lookahead slices, and so the number of pipeline stages
    function automatic int unsigned num_blk(input int unsigned width, input int unsigned block);
        return width / block;
    endfunction

    // Stage payload layout at the default width. The top level declares the
    // same layout sized by its own WIDTH parameter.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] sum_lo;
        logic                 carry;
        logic [DEF_WIDTH-1:0] a_hi;
        logic [DEF_WIDTH-1:0] b_hi;
        logic                 c_msb;
    } stage_t;

endpackage

// File: rtl/cla_block.sv
// BLOCK-wide combinational carry-lookahead slice (generate/propagate form).
module cla_block #(
    parameter int unsigned BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             acc;
    logic             prod;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry c[i+1] is the flat OR of g[j] & p[i..j+1] terms plus the
    // fully propagated carry-in, so no carry ripples through the slice.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        prod = 1'b0;
        c[0] = ci;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int unsigned n = 0; n < i; n++) begin
                acc  = acc | (prod & g[i-1-n]);
                prod = prod & p[i-1-n];
            end
            acc    = acc | (prod & ci);
            c[i+1] = acc;
        end
    end

    assign s        = p ^ c[BLOCK-1:0];
    assign co       = c[BLOCK];
    assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor, one BLOCK-bit slice
// resolved per stage, with a whole-pipeline valid/ready stall.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NUM_BLK = num_blk(WIDTH, BLOCK);
    localparam int unsigned LAST    = NUM_BLK - 1;

    if (BLOCK < 1 || BLOCK > 16 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK, BLOCK in 1..16");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum_lo;
        logic             carry;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic             c_msb;
    } pipe_t;

    pipe_t            st  [NUM_BLK];
    pipe_t            src [NUM_BLK];
    pipe_t            nx  [NUM_BLK];
    logic [BLOCK-1:0] blk_s [NUM_BLK];
    logic [NUM_BLK-1:0] blk_co;
    logic [NUM_BLK-1:0] blk_cm;
    logic             advance;
    logic             zero_q;

    assign advance  = !st[LAST].valid || out_ready;
    assign in_ready = rst_n && advance;

    // Stage inputs: operand transform for stage 0, previous register otherwise
    always_comb begin
        for (int unsigned k = 0; k < NUM_BLK; k++) begin
            src[k] = '0;
        end
        if (in_valid) begin
            src[0].valid = 1'b1;
            src[0].carry = (sub == OP_SUB) ? 1'b1 : cin;
            src[0].a_hi  = a;
            src[0].b_hi  = (sub == OP_SUB) ? ~b : b;
        end
        for (int unsigned k = 1; k < NUM_BLK; k++) begin
            src[k] = st[k-1];
        end
    end

    for (genvar gk = 0; gk < NUM_BLK; gk++) begin : g_blk
        cla_block #(.BLOCK(BLOCK)) u_cla (
            .a        (src[gk].a_hi[gk*BLOCK +: BLOCK]),
            .b        (src[gk].b_hi[gk*BLOCK +: BLOCK]),
            .ci       (src[gk].carry),
            .s        (blk_s[gk]),
            .co       (blk_co[gk]),
            .c_msb_in (blk_cm[gk])
        );
    end

    // Next stage contents: merge the slice result into the carried payload
    always_comb begin
        for (int unsigned k = 0; k < NUM_BLK; k++) begin
            nx[k]                           = src[k];
            nx[k].sum_lo[k*BLOCK +: BLOCK]  = blk_s[k];
            nx[k].carry                     = blk_co[k];
            nx[k].c_msb                     = blk_cm[k];
        end
    end

    // Stage registers: whole pipeline shifts together unless output is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_BLK; k++) begin
                st[k] <= '0;
            end
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < NUM_BLK; k++) begin
                st[k] <= nx[k];
            end
            zero_q <= nx[LAST].valid && (nx[LAST].sum_lo == '0);
        end
    end

    assign out_valid = st[LAST].valid;
    assign sum       = st[LAST].sum_lo;
    assign cout      = st[LAST].carry;
    assign ovf       = st[LAST].c_msb ^ st[LAST].carry;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder at WIDTH=32, BLOCK=8.
module tb_pipelined_cla_adder;

    localparam int LAT = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int total;
    int bad;

    typedef struct {
        logic        v;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } slot_t;

    slot_t pipe [LAT];

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic from signed/unsigned integer semantics
    function automatic slot_t ref_op(input logic [31:0] ia, input logic [31:0] ib,
                                     input logic icin, input logic isub);
        slot_t       r;
        longint      sa;
        longint      sb;
        longint      sres;
        logic [32:0] u;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        r.v = 1'b1;
        if (isub) begin
            sres   = sa - sb;
            r.sum  = ia - ib;
            r.cout = (ia >= ib);
        end else begin
            sres   = sa + sb + longint'(icin);
            u      = {1'b0, ia} + {1'b0, ib} + {32'd0, icin};
            r.sum  = u[31:0];
            r.cout = u[32];
        end
        r.ovf  = (sres > SMAX) || (sres < SMIN);
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] rnd32();
        logic [31:0] pool [6];
        pool[0] = 32'h0000_0000;
        pool[1] = 32'hFFFF_FFFF;
        pool[2] = 32'h7FFF_FFFF;
        pool[3] = 32'h8000_0000;
        pool[4] = 32'h0000_0001;
        pool[5] = 32'h0000_00FF;
        if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive, compare against the model, clock, advance the model
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic icin, input logic isub, input logic ordy);
        logic m_ov;
        logic m_ir;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        out_ready = ordy;
        #1;
        m_ov = pipe[LAT-1].v;
        m_ir = rst_n && (!m_ov || ordy);
        chk("in_ready", in_ready, m_ir);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("sum",  sum,  pipe[LAT-1].sum);
            chk("cout", cout, pipe[LAT-1].cout);
            chk("ovf",  ovf,  pipe[LAT-1].ovf);
            chk("zero", zero, pipe[LAT-1].zero);
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] = '{default: '0};
        end else if (!m_ov || ordy) begin
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            if (iv) pipe[0] = ref_op(ia, ib, icin, isub);
            else    pipe[0] = '{default: '0};
        end
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rnd_issue(input logic ordy);
        step(1'b1, rnd32(), rnd32(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_in_ready",  in_ready,  32'd0);
        chk("rst_sum",       sum,       32'd0);
        chk("rst_cout",      cout,      32'd0);
        chk("rst_ovf",       ovf,       32'd0);
        chk("rst_zero",      zero,      32'd0);
    endtask

    // Issue one operation, wait the pipeline latency, compare to literal values
    task automatic directed(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                            input logic icin, input logic isub, input logic [31:0] esum,
                            input logic ecout, input logic eovf, input logic ezero);
        step(1'b1, ia, ib, icin, isub, 1'b1);
        idle(LAT - 1);
        chk({tag, "_valid"}, out_valid, 32'd1);
        chk({tag, "_sum"},   sum,       esum);
        chk({tag, "_cout"},  cout,      ecout);
        chk({tag, "_ovf"},   ovf,       eovf);
        chk({tag, "_zero"},  zero,      ezero);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < LAT; i++) pipe[i] = '{default: '0};

        // Reset state
        @(posedge clk);
        #2;
        step(1'b1, 32'h1234_5678, 32'h1, 1'b0, 1'b0, 1'b1);
        check_reset_outputs();
        rst_n = 1'b1;
        idle(2);

        // Directed corner cases
        directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h8000_0001, 1'b0, 1'b1, 1'b0);
        directed("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("sub_brw",  32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Streaming at full rate
        for (int i = 0; i < 200; i++) rnd_issue(1'b1);
        idle(LAT + 1);

        // Backpressure: fill, hold for 5 cycles, then release while issuing
        for (int i = 0; i < LAT; i++) rnd_issue(1'b0);
        for (int i = 0; i < 5; i++) rnd_issue(1'b0);
        for (int i = 0; i < 8; i++) rnd_issue(1'b1);
        idle(LAT + 1);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) rnd_issue(1'b1);
        rst_n = 1'b0;
        rnd_issue(1'b1);
        check_reset_outputs();
        rst_n = 1'b1;
        idle(LAT + 2);
        directed("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Mixed bubbles and random backpressure
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) != 0) rnd_issue(1'($urandom_range(0, 2) != 0));
            else step(1'b0, rnd32(), rnd32(), 1'b0, 1'b0, 1'($urandom_range(0, 2) != 0));
        end
        idle(LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
